// File: rtl/ram_rd_chk.sv
// Sweeps a RAM read port over DEPTH words after each rising edge of rd_flag and counts words that differ from (addr + EXP_BASE).
// Define RAM_RD_CHK_FIRST_ERR_EN to add first_err_addr/first_err_data capture of the first mismatching word.
module ram_rd_chk #(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int EXP_BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_flag,
  input  logic [DW-1:0] ram_rd_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt
`ifdef RAM_RD_CHK_FIRST_ERR_EN
  ,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] EXP_OFF   = DW'(EXP_BASE);

  state_t        state_q, state_d;
  logic          flag_q, flag_d;
  logic          arm_q, arm_d;
  logic          start_q, start_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0] pipe_addr_q [RD_LAT];
  logic [AW-1:0] pipe_addr_d [RD_LAT];

  logic          chk_vld;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] exp_data;
  logic          mismatch;

  // arm_q swallows the first post-reset cycle so a level already high at release is not an edge.
  always_comb begin
    flag_d  = rd_flag;
    arm_d   = 1'b1;
    start_d = arm_q & rd_flag & ~flag_q;
  end

  // Valid bit and address travel with the read so each returning word is compared to its own address.
  always_comb begin
    vld_d[0]       = rd_en_q;
    pipe_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]       = vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  assign chk_vld  = vld_q[RD_LAT-1];
  assign chk_addr = pipe_addr_q[RD_LAT-1];
  assign exp_data = DW'(chk_addr) + EXP_OFF;
  assign mismatch = chk_vld && (ram_rd_data != exp_data);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    if (mismatch) err_cnt_d = err_cnt_q + (AW+1)'(1);
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d   = READ;
          rd_en_d   = 1'b1;
          addr_d    = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_cnt_d = '0;
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        // Pipeline empties on this edge, so this cycle holds the final compare.
        if (vld_d == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the compare pipeline is reset too; a stale valid bit would corrupt the next err_cnt.
      state_q   <= IDLE;
      flag_q    <= 1'b0;
      arm_q     <= 1'b0;
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      vld_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      flag_q      <= flag_d;
      arm_q       <= arm_d;
      start_q     <= start_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      vld_q       <= vld_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_cnt_q;

`ifdef RAM_RD_CHK_FIRST_ERR_EN
  logic [AW-1:0] ferr_addr_q, ferr_addr_d;
  logic [DW-1:0] ferr_data_q, ferr_data_d;

  // err_cnt_q still zero means no earlier mismatch in this pass.
  always_comb begin
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    if (state_q == IDLE && start_q) begin
      ferr_addr_d = '0;
      ferr_data_d = '0;
    end else if (mismatch && err_cnt_q == '0) begin
      ferr_addr_d = chk_addr;
      ferr_data_d = ram_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
`endif

endmodule

// File: doc/ram_rd_chk.md
RAM_RD_CHK -- requirements
Module: ram_rd_chk

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of RAM words swept per pass.
REQ-002 The module SHALL have parameter AW, default 6, giving the address width; DEPTH SHALL equal 2**AW.
REQ-003 The module SHALL have parameter DW, default 8, giving the data width.
REQ-004 The module SHALL have parameter RD_LAT, default 1, range 1..3, giving the RAM read latency in clk cycles from ram_rd_en/ram_rd_addr to valid ram_rd_data.
REQ-005 The module SHALL have parameter EXP_BASE, default 0, giving the pattern offset: expected word at address A = (A + EXP_BASE) mod 2**DW.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  reset: asynchronous, active-high.
REQ-008 rd_flag  input  1  writer-side "fill complete" level; its rising edge starts one check pass.
REQ-009 ram_rd_data  input  DW  RAM port-B read data.
REQ-010 ram_rd_en  output  1  RAM port-B enable, one word per cycle.
REQ-011 ram_rd_addr  output  AW  RAM port-B address.
REQ-012 busy  output  1  high from pass start until the last compare completes.
REQ-013 done  output  1  one-cycle pulse when the last compare completes.
REQ-014 pass  output  1  high after done when err_cnt is 0; held until the next pass starts.
REQ-015 err_cnt  output  AW+1  mismatch count of the current or last pass.

Function
REQ-016 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-017 The start event SHALL be a registered rising-edge detect of rd_flag, so start asserts one cycle after rd_flag goes high.
REQ-018 IDLE->READ on start, which clears err_cnt and pass and sets ram_rd_addr to 0.
REQ-019 In READ, ram_rd_en SHALL be 1 every cycle, with ram_rd_addr incrementing by 1 from 0 to DEPTH-1 (DEPTH consecutive cycles, no gaps).
REQ-020 READ->DRAIN in the cycle after address DEPTH-1 is issued; ram_rd_en SHALL be 0 in DRAIN and ram_rd_addr SHALL hold DEPTH-1.
REQ-021 The block SHALL carry a valid bit and address through an RD_LAT-deep shift pipeline and compare ram_rd_data against the expected pattern only when the delayed valid bit is set.
REQ-022 On each mismatch, err_cnt SHALL increment by 1; it cannot overflow, since the maximum is DEPTH and it is AW+1 bits wide.
REQ-023 DRAIN->DONE when the pipeline is empty, i.e. after the compare for address DEPTH-1 is done; done SHALL pulse in that cycle.
REQ-024 In that same cycle, pass SHALL be set to (final err_cnt == 0), including a mismatch on the last word.
REQ-025 DONE->IDLE unconditionally after one cycle.
REQ-026 busy SHALL be 1 in READ and DRAIN, and 0 otherwise.
REQ-027 Rising edges of rd_flag during READ, DRAIN or DONE SHALL be ignored; they do not restart or queue a pass.
REQ-028 A new rising edge in IDLE SHALL start a fresh pass.
REQ-029 If rd_flag stays high, only one pass SHALL run; rd_flag must fall and rise again to start another.
REQ-030 Total pass length from start to done SHALL be DEPTH+RD_LAT+1 cycles.

Reset
REQ-031 While rst is high, the state SHALL be IDLE and ram_rd_en, busy, done and pass SHALL be 0.
REQ-032 While rst is high, ram_rd_addr, err_cnt, the pipeline and the edge-detect register SHALL be 0.
REQ-033 rst asserted mid-pass SHALL abort immediately with no done pulse.
REQ-034 If rd_flag is already high when rst releases, it SHALL NOT count as an edge; this is achieved by resetting the edge register to 0 and sampling rd_flag in the first post-reset cycle.

Configuration
REQ-035 Macro RAM_RD_CHK_FIRST_ERR_EN SHALL control first-error capture.
REQ-036 When RAM_RD_CHK_FIRST_ERR_EN is defined, the block SHALL add outputs first_err_addr (AW) and first_err_data (DW).
REQ-037 first_err_addr and first_err_data SHALL latch the address and read data of the first mismatch in a pass.
REQ-038 first_err_addr and first_err_data SHALL be cleared to 0 at pass start and on rst, and SHALL hold their values until the next start.
REQ-039 When RAM_RD_CHK_FIRST_ERR_EN is undefined, these ports and registers SHALL be absent, with all other behaviour identical.

Verification
REQ-040 Pattern match: RAM preloaded with data=addr, defaults, rd_flag rising -> addresses 0..63 issued over 64 cycles, done 66 cycles after start, pass=1, err_cnt=0.
REQ-041 Single error: word 17 corrupted to 0xFF -> err_cnt=1, pass=0; with macro defined, first_err_addr=17 and first_err_data=0xFF.
REQ-042 Last-word error: word 63 corrupted -> err_cnt=1, pass=0 in the done cycle.
REQ-043 All wrong: EXP_BASE=1 with RAM data=addr -> err_cnt=64, no wrap.
REQ-044 Edge handling: rd_flag toggled mid-READ -> no restart, exactly one done; rd_flag held high through done -> no second pass.
REQ-045 Reset: rst pulsed at address 30 -> outputs zero and no done; later rd_flag rise -> full pass from address 0; repeat with RD_LAT=3 -> done 68 cycles after start.
